// File: rtl/uart_tx_gen_if.sv
// Host-side write interface of the UART transmitter: FIFO push strobe/data
// plus the FIFO status the host needs for flow control.
interface uart_tx_gen_if #(
    parameter int FIFO_AW = 2,
    parameter int DATA_W  = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              txrdy;
    logic              overflow;
    logic [FIFO_AW:0]  fifo_count;

    modport master (
        output wr_en, wr_data,
        input  txrdy, overflow, fifo_count
    );

    modport slave (
        input  wr_en, wr_data,
        output txrdy, overflow, fifo_count
    );
endinterface

// File: rtl/uart_tx_gen.sv
// UART transmitter with internal TX FIFO, 5..8 data bits, five parity modes,
// 1/1.5/2 stop bits and break generation, timed by a 16x oversample strobe.
module uart_tx_gen #(
    parameter int FIFO_AW = 2,
    parameter int DATA_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          baud16_pulse,
    uart_tx_gen_if.slave  host,
    input  logic [1:0]    char_len,
    input  logic [2:0]    parity_mode,
    input  logic [1:0]    stop_mode,
    input  logic          break_req,
    output logic          tx,
    output logic          tx_busy,
    output logic          tx_done
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                overflow_q;
    logic                full, push, load, brk_enter;
    logic [DATA_W-1:0]   shift;
    logic [3:0]          tick_cnt;
    logic [2:0]          bit_cnt;
    logic [1:0]          lat_len;
    logic [2:0]          lat_parity;
    logic [2:0]          lat_stop_halves;
    logic                par_acc;
    logic                bit_end, half_end, last_data, has_parity, stop_end;

    assign full            = (count == FULL_CNT);
    assign push            = host.wr_en && !full;
    assign brk_enter       = (state == IDLE) && break_req;
    assign load            = (state == IDLE) && !break_req && (count != '0);
    assign host.txrdy      = !full;
    assign host.fifo_count = count;
    assign host.overflow   = overflow_q;

    assign bit_end    = baud16_pulse && (tick_cnt == 4'd15);
    assign half_end   = baud16_pulse && (tick_cnt[2:0] == 3'd7);
    assign last_data  = (bit_cnt == ({1'b0, lat_len} + 3'd4));
    assign has_parity = (lat_parity == 3'd1) || (lat_parity == 3'd2) ||
                        (lat_parity == 3'd3) || (lat_parity == 3'd4);
    // Stop periods are counted in half bits so 1.5 stop bits fits the same counter.
    assign stop_end   = half_end && (bit_cnt == (lat_stop_halves - 3'd1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= host.wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (break_req) begin
                    state_nxt = BREAK;
                end else if (count != '0) begin
                    state_nxt = START;
                end
            end
            START:   if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end && last_data) begin
                    state_nxt = has_parity ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_end) state_nxt = STOP;
            STOP:    if (stop_end) state_nxt = IDLE;
            BREAK:   if (bit_end && !break_req) state_nxt = STOP;
            default: state_nxt = IDLE;
        endcase
    end

    // Config is captured at frame load so mid-frame changes only affect the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift           <= '0;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            lat_len         <= '0;
            lat_parity      <= '0;
            lat_stop_halves <= 3'd2;
            par_acc         <= 1'b0;
            tx_done         <= 1'b0;
        end else begin
            tx_done <= (state == STOP) && stop_end;
            if (load) begin
                shift      <= mem[rd_ptr];
                lat_len    <= char_len;
                lat_parity <= parity_mode;
                case (stop_mode)
                    2'b00:   lat_stop_halves <= 3'd2;
                    2'b01:   lat_stop_halves <= 3'd3;
                    default: lat_stop_halves <= 3'd4;
                endcase
                tick_cnt <= '0;
                bit_cnt  <= '0;
                par_acc  <= 1'b0;
            end else if (brk_enter) begin
                tick_cnt        <= '0;
                bit_cnt         <= '0;
                lat_stop_halves <= 3'd2;
            end else if ((state != IDLE) && baud16_pulse) begin
                tick_cnt <= tick_cnt + 4'd1;
                case (state)
                    DATA: begin
                        if (bit_end) begin
                            par_acc <= par_acc ^ shift[bit_cnt];
                            bit_cnt <= last_data ? 3'd0 : bit_cnt + 3'd1;
                        end
                    end
                    STOP: begin
                        if (stop_end) begin
                            bit_cnt <= '0;
                            par_acc <= 1'b0;
                        end else if (half_end) begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: begin
                        if (bit_end) begin
                            bit_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        tx      = 1'b1;
        tx_busy = (state != IDLE);
        case (state)
            START: tx = 1'b0;
            DATA:  tx = shift[bit_cnt];
            PARITY: begin
                case (lat_parity)
                    3'd1:    tx = ~par_acc;
                    3'd2:    tx = par_acc;
                    3'd4:    tx = 1'b0;
                    default: tx = 1'b1;
                endcase
            end
            BREAK:   tx = 1'b0;
            default: tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: a monitor records tx on every baud16
// pulse and compares each completed frame against a scoreboard queue.
module tb_uart_tx_gen;
    logic       clk;
    logic       reset;
    logic       baud16_pulse;
    logic       break_req;
    logic [1:0] char_len;
    logic [2:0] parity_mode;
    logic [1:0] stop_mode;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_gen_if #(.FIFO_AW(2), .DATA_W(8)) host_if ();

    uart_tx_gen #(.FIFO_AW(2), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .baud16_pulse (baud16_pulse),
        .host         (host_if),
        .char_len     (char_len),
        .parity_mode  (parity_mode),
        .stop_mode    (stop_mode),
        .break_req    (break_req),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done)
    );

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          stop_ticks;
        bit          brk;
        int          min_low;
        logic [7:0]  data;
    } frame_t;

    frame_t sb[$];
    logic   samp[$];
    int     checks   = 0;
    int     failures = 0;
    int     done_cnt = 0;
    int     frame_no = 0;
    bit     mon_en   = 1'b1;
    bit     in_frame = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One baud16 strobe every third clock, changed shortly after the rising edge.
    initial begin
        int pdiv;
        pdiv = 0;
        baud16_pulse = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            baud16_pulse = (pdiv == 0);
            pdiv = (pdiv == 2) ? 0 : pdiv + 1;
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic frame_t make_frame(input logic [7:0] d, input logic [1:0] cl,
                                          input logic [2:0] pm, input logic [1:0] sm);
        frame_t f;
        int     n;
        logic   x;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        f.brk     = 1'b0;
        f.min_low = 0;
        f.data    = d;
        n = 5 + int'(cl);
        x = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[1+i] = d[i];
            x = x ^ d[i];
        end
        f.nbits = 1 + n;
        case (pm)
            3'd1: begin f.bits[1+n] = ~x;   f.nbits++; end
            3'd2: begin f.bits[1+n] = x;    f.nbits++; end
            3'd3: begin f.bits[1+n] = 1'b1; f.nbits++; end
            3'd4: begin f.bits[1+n] = 1'b0; f.nbits++; end
            default: ;
        endcase
        f.stop_ticks = (sm == 2'b00) ? 16 : (sm == 2'b01) ? 24 : 32;
        return f;
    endfunction

    function automatic frame_t make_break(input int min_low);
        frame_t f;
        f.bits       = '0;
        f.nbits      = 0;
        f.stop_ticks = 16;
        f.brk        = 1'b1;
        f.min_low    = min_low;
        f.data       = 8'h00;
        return f;
    endfunction

    // Frame monitor: a frame begins at the first pulse with tx low and ends at tx_done.
    initial begin
        frame_t e;
        int     n, low, bad_idx, exp_len;
        logic   expb;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_frame = 1'b0;
                samp.delete();
            end else if (tx_done === 1'b1) begin
                done_cnt++;
                frame_no++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL frame_%0d: got unexpected frame of %0d samples, expected none",
                             frame_no, samp.size());
                end else begin
                    e = sb.pop_front();
                    n = samp.size();
                    bad_idx = -1;
                    if (!e.brk) begin
                        exp_len = e.nbits * 16 + e.stop_ticks;
                        if (n != exp_len) begin
                            bad_idx = n;
                        end else begin
                            for (int i = 0; i < n; i++) begin
                                expb = (i < e.nbits * 16) ? e.bits[i/16] : 1'b1;
                                if (samp[i] !== expb && bad_idx < 0) bad_idx = i;
                            end
                        end
                    end else begin
                        exp_len = e.min_low + 16;
                        low = n - 16;
                        if (low < e.min_low || (low % 16) != 0) begin
                            bad_idx = n;
                        end else begin
                            for (int i = 0; i < n; i++) begin
                                expb = (i < low) ? 1'b0 : 1'b1;
                                if (samp[i] !== expb && bad_idx < 0) bad_idx = i;
                            end
                        end
                    end
                    if (bad_idx >= 0) begin
                        failures++;
                        $display("[TB] FAIL frame_%0d: got %0d samples (first bad index %0d), expected %0d samples for data 0x%02h brk=%0d",
                                 frame_no, n, bad_idx, exp_len, e.data, e.brk);
                    end
                end
                in_frame = 1'b0;
                samp.delete();
            end else if (baud16_pulse === 1'b1) begin
                if (in_frame) begin
                    samp.push_back(tx);
                end else if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    samp.push_back(tx);
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit expect_send);
        @(negedge clk);
        host_if.wr_en   = 1'b1;
        host_if.wr_data = d;
        if (expect_send) sb.push_back(make_frame(d, char_len, parity_mode, stop_mode));
        @(negedge clk);
        host_if.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int max_clks);
        int n;
        n = 0;
        while ((sb.size() != 0 || tx_busy !== 1'b0) && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || tx_busy !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle_timeout: got %0d frames pending busy=%b, expected 0 pending busy=0",
                     sb.size(), tx_busy);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input int max_clks);
        int n;
        n = 0;
        while (tx_done !== 1'b1 && n < max_clks) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL done_timeout: got tx_done=%b, expected 1", tx_done);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks += 6;
        if (tx !== 1'b1)                 begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        if (host_if.txrdy !== 1'b1)      begin failures++; $display("[TB] FAIL reset_txrdy: got %b expected 1", host_if.txrdy); end
        if (tx_busy !== 1'b0)            begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
        if (tx_done !== 1'b0)            begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
        if (host_if.overflow !== 1'b0)   begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", host_if.overflow); end
        if (host_if.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", host_if.fifo_count); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int d0;
        char_len = 2'b11; parity_mode = 3'd0; stop_mode = 2'b00;
        d0 = done_cnt;
        write_byte(8'hA5, 1'b1);
        checks += 2;
        if (host_if.fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL latency_count: got %0d expected 1", host_if.fifo_count); end
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL latency_tx_n1: got %b expected 1", tx); end
        @(negedge clk);
        checks += 2;
        if (tx !== 1'b0) begin failures++; $display("[TB] FAIL latency_tx_n2: got %b expected 0", tx); end
        if (tx_busy !== 1'b1) begin failures++; $display("[TB] FAIL latency_busy: got %b expected 1", tx_busy); end
        wait_idle(3000);
        checks++;
        if (done_cnt - d0 != 1) begin failures++; $display("[TB] FAIL basic_done_count: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_parity;
        char_len = 2'b00; stop_mode = 2'b00;
        for (int m = 1; m <= 4; m++) begin
            parity_mode = 3'(m);
            write_byte(8'h13, 1'b1);
            wait_idle(3000);
        end
        char_len = 2'b11; parity_mode = 3'd1;
        write_byte(8'hB7, 1'b1);
        wait_idle(3000);
        char_len = 2'b10; parity_mode = 3'd2;
        write_byte(8'h6C, 1'b1);
        wait_idle(3000);
    endtask

    task automatic test_stop;
        char_len = 2'b11; parity_mode = 3'd0; stop_mode = 2'b01;
        write_byte(8'h3C, 1'b1);
        @(negedge clk);
        stop_mode = 2'b10;
        write_byte(8'hC3, 1'b1);
        wait_done(3000);
        @(negedge clk);
        checks += 2;
        if (tx !== 1'b0) begin failures++; $display("[TB] FAIL b2b_start_tx: got %b expected 0", tx); end
        if (tx_busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_start_busy: got %b expected 1", tx_busy); end
        wait_idle(3000);
        stop_mode = 2'b11; parity_mode = 3'd5;
        write_byte(8'h5E, 1'b1);
        wait_idle(3000);
        stop_mode = 2'b00; parity_mode = 3'd0;
    endtask

    task automatic test_fifo;
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [7:0] dat [6]     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        char_len = 2'b11; parity_mode = 3'd0; stop_mode = 2'b00;
        @(negedge clk);
        host_if.wr_en   = 1'b1;
        host_if.wr_data = dat[0];
        sb.push_back(make_frame(dat[0], char_len, parity_mode, stop_mode));
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            checks += 3;
            if (host_if.fifo_count !== exp_cnt[i-1]) begin failures++; $display("[TB] FAIL fifo_count_%0d: got %0d expected %0d", i, host_if.fifo_count, exp_cnt[i-1]); end
            if (host_if.txrdy !== (exp_cnt[i-1] != 3'd4)) begin failures++; $display("[TB] FAIL fifo_txrdy_%0d: got %b expected %b", i, host_if.txrdy, exp_cnt[i-1] != 3'd4); end
            if (host_if.overflow !== 1'b0) begin failures++; $display("[TB] FAIL fifo_no_overflow_%0d: got %b expected 0", i, host_if.overflow); end
            host_if.wr_data = dat[i];
            if (i < 5) sb.push_back(make_frame(dat[i], char_len, parity_mode, stop_mode));
        end
        @(negedge clk);
        host_if.wr_en = 1'b0;
        checks += 3;
        if (host_if.fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL fifo_full_count: got %0d expected 4", host_if.fifo_count); end
        if (host_if.overflow !== 1'b1) begin failures++; $display("[TB] FAIL fifo_overflow: got %b expected 1", host_if.overflow); end
        if (host_if.txrdy !== 1'b0) begin failures++; $display("[TB] FAIL fifo_full_txrdy: got %b expected 0", host_if.txrdy); end
        @(negedge clk);
        checks++;
        if (host_if.overflow !== 1'b0) begin failures++; $display("[TB] FAIL fifo_overflow_pulse: got %b expected 0", host_if.overflow); end
        wait_idle(15000);
    endtask

    task automatic test_break;
        char_len = 2'b11; parity_mode = 3'd0; stop_mode = 2'b00;
        write_byte(8'h5A, 1'b1);
        repeat (100) @(negedge clk);
        break_req = 1'b1;
        sb.push_back(make_break(32));
        write_byte(8'h81, 1'b1);
        checks++;
        if (host_if.fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL break_write_accept: got %0d expected 1", host_if.fifo_count); end
        wait_done(3000);
        repeat (64) @(negedge clk);
        checks += 3;
        if (tx !== 1'b0) begin failures++; $display("[TB] FAIL break_low: got %b expected 0", tx); end
        if (tx_busy !== 1'b1) begin failures++; $display("[TB] FAIL break_busy: got %b expected 1", tx_busy); end
        if (host_if.fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL break_priority: got %0d expected 1", host_if.fifo_count); end
        break_req = 1'b0;
        wait_idle(5000);
    endtask

    task automatic test_cfg_change;
        char_len = 2'b11; parity_mode = 3'd0; stop_mode = 2'b00;
        write_byte(8'hF0, 1'b1);
        repeat (2) @(negedge clk);
        char_len = 2'b00;
        wait_idle(3000);
        char_len = 2'b11;
    endtask

    task automatic test_reset_mid;
        char_len = 2'b11; parity_mode = 3'd0; stop_mode = 2'b00;
        mon_en = 1'b0;
        write_byte(8'h01, 1'b0);
        write_byte(8'h02, 1'b0);
        write_byte(8'h03, 1'b0);
        write_byte(8'h04, 1'b0);
        repeat (100) @(negedge clk);
        checks++;
        if (host_if.fifo_count !== 3'd3) begin failures++; $display("[TB] FAIL reset_mid_queued: got %0d expected 3", host_if.fifo_count); end
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid_tx: got %b expected 1", tx); end
        if (host_if.fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_mid_count: got %0d expected 0", host_if.fifo_count); end
        if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_busy: got %b expected 0", tx_busy); end
        if (host_if.txrdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid_txrdy: got %b expected 1", host_if.txrdy); end
        reset = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_stay_idle: got %b expected 0", tx_busy); end
        write_byte(8'h99, 1'b1);
        wait_idle(3000);
    endtask

    initial begin
        reset           = 1'b1;
        break_req       = 1'b0;
        char_len        = 2'b11;
        parity_mode     = 3'd0;
        stop_mode       = 2'b00;
        host_if.wr_en   = 1'b0;
        host_if.wr_data = 8'h00;
        $display("[TB] start");
        test_reset();
        test_basic();
        test_parity();
        test_stop();
        test_fifo();
        test_break();
        test_cfg_change();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin failures++; $display("[TB] FAIL leftover_frames: got %0d expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_gen.md
Name: uart_tx_gen

Overview:
- Next-generation UART transmitter that supersedes the fixed 7/8-bit transmitter.
- Adds a parametrised internal TX FIFO and runtime-selectable character length (5–8).
- Adds five parity modes, 1/1.5/2 stop bits and break generation.
- Runs entirely on the system clock; bit timing comes from a 16x oversample pulse supplied by the baud generator.

Parameters:
- FIFO_AW, 2, log2 of FIFO depth. Depth = 2**FIFO_AW; legal range 1..6.
- DATA_W, 8, storage width of the FIFO and of wr_data. Fixed at 8; only char_len bits are sent.

Ports:
- clk input 1: system clock.
- reset input 1: synchronous, active-high reset.
- baud16_pulse input 1: one-clk strobe at 16x baud rate.
- wr_en input 1: write strobe, pushes wr_data into the FIFO.
- wr_data input DATA_W: character to send, LSB first.
- char_len input 2: 00=5, 01=6, 10=7, 11=8 data bits.
- parity_mode input 3: 000=none, 001=odd, 010=even, 011=mark(1), 100=space(0); 101–111 treated as none.
- stop_mode input 2: 00=1, 01=1.5, 10=2 stop bits; 11 treated as 2.
- break_req input 1: request to hold tx low (break condition).
- tx output 1: serial line, idle high.
- txrdy output 1: FIFO not full.
- tx_busy output 1: state != IDLE.
- tx_done output 1: one-clk pulse at the end of each stop period.
- overflow output 1: one-clk pulse when a write is dropped.
- fifo_count output FIFO_AW+1: current FIFO occupancy.

Behaviour:
- Reset values: tx=1, txrdy=1, tx_busy=0, tx_done=0, overflow=0, fifo_count=0. FIFO pointers=0, state=IDLE, tick_cnt=0, bit_cnt=0.
- Reset mid-frame aborts the frame immediately; tx=1 the next clk.
- FIFO is synchronous, registered count.
  - wr_en with fifo_count==depth: write dropped, overflow=1 next clk. This holds even if a pop occurs in the same clk.
  - Push and pop in the same clk (not full): count unchanged.
  - Pointers wrap modulo depth.
  - txrdy = (fifo_count != depth), combinational from the registered count.
- Config latch: char_len, parity_mode and stop_mode are latched when a frame is loaded. Mid-frame changes affect the next frame only.
- tick_cnt (4 bits) increments on baud16_pulse only. A bit period ends on a baud16_pulse with tick_cnt==15.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - tx=1.
  - If break_req=1: go to BREAK; tx=0 next clk. Break has priority over FIFO data.
  - Else if fifo_count!=0: pop the head word into the shift register, latch config, clear tick_cnt, go to START; tx=0 next clk.
  - No baud16_pulse is needed to leave IDLE.
- Latency: wr_en into an empty FIFO at clk N gives fifo_count=1 at N+1 and tx=0 at N+2.
- START: 16 ticks low, then go to DATA with bit_cnt=0.
- DATA:
  - tx = shift[bit_cnt] for 16 ticks each.
  - Parity accumulator XORs each bit sent.
  - After bit_cnt == char_len+4: go to PARITY if the parity mode is not none, else STOP.
- PARITY: one bit (16 ticks).
  - odd: ~xor(data).
  - even: xor(data).
  - mark: 1.
  - space: 0.
- STOP:
  - tx=1 for 16, 24 or 32 ticks (1, 1.5 or 2 stop bits).
  - On the final tick: tx_done=1 for one clk, parity accumulator cleared, go to IDLE.
  - A back-to-back frame then starts START 1 clk later if the FIFO is non-empty.
- Break timing: break_req asserted mid-frame has no effect until IDLE is reached; the current frame completes.
- BREAK:
  - tx=0 while break_req=1, with a minimum of 16 ticks.
  - Exit only on a bit boundary with break_req=0: tx=1 and enter STOP using 1 stop bit (16 ticks mark), then IDLE.
  - FIFO writes are still accepted during BREAK.
- Bit period rule: baud16_pulse absent means tx holds its value. All bit periods are an exact multiple of 16 pulses; the first start tick counts from the first baud16_pulse after entry.

Test Plan:
- Reset, then wr 0xA5 with char_len=11, parity none, stop 1 → tx sequence 0,1,0,1,0,0,1,0,1,1. Each bit = 16 pulses; tx_done pulses once; tx=0 exactly 2 clks after wr_en.
- char_len=00, parity odd, data 0x13 (5 bits 10011b, LSB first 1,1,0,0,1) → parity bit 0, total frame 8 bits; repeat with even → parity 1. Mark/space → 1/0.
- stop_mode=01, then 10, two back-to-back bytes → stop high exactly 24 then 32 pulses; second START begins 1 clk after tx_done with no idle bit.
- FIFO_AW=2: 5 writes in 5 consecutive clks while IDLE → 4 stored, fifo_count peaks ≤4, txrdy=0 while full; a write at count 4 gives overflow=1 and is dropped. All stored bytes transmit in order.
- break_req asserted mid-frame → frame completes, then tx=0 held ≥16 pulses. Release mid-bit → tx stays low until the bit boundary, then 16 pulses high, then queued data sends.
- reset asserted during DATA with 3 bytes queued → next clk tx=1, fifo_count=0, tx_busy=0. Changing char_len mid-frame leaves the current frame length unchanged.
